apuf_array_eval: RTL and testbench

Multi-channel, parametrised arbiter-PUF evaluator. It contains CHANNELS independent STAGES-deep arbiter delay chains built from the existing mux switch and arbiter flop cells, and a clocked controller around them. The controller accepts a challenge over a valid/ready handshake, runs VOTES launch/capture rounds, majority-votes each channel, and returns a CHANNELS-bit response over a second handshake. It sits between the challenge source (host/LFSR) and the response consumer in the PUF datapath.

---
 rtl/apuf_array_eval.sv | 270 +++++++++++++++++++++++++++
 tb/tb_apuf_array_eval.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apuf_array_eval.sv
`timescale 1ns/1ps
// apuf_array_eval -- multi-channel arbiter-PUF evaluator.
// CHANNELS arbiter delay chains share one launch register. A controller runs
// VOTES launch/capture rounds per challenge, majority-votes each channel and
// returns the response over a valid/ready handshake.
// Build option APUF_STABILITY_EN: adds per-channel zero counters so that
// resp_stable reports true unanimity; without it resp_stable reads all-ones.
module apuf_array_eval #(
    parameter int STAGES        = 37,
    parameter int CHANNELS      = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int VOTES         = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chal_valid,
    output logic                chal_ready,
    input  logic [STAGES-1:0]   chal,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [CHANNELS-1:0] resp,
    output logic [CHANNELS-1:0] resp_stable,
    output logic                busy
);
    localparam int VW = $clog2(VOTES + 1);
    localparam int CW = $clog2(SETTLE_CYCLES + 2);

    localparam logic [CW-1:0] ARM_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] FIRE_LAST = CW'(SETTLE_CYCLES + 1);
    localparam logic [VW-1:0] VOTES_V   = VW'(VOTES);
    localparam logic [VW-1:0] HALF_V    = VW'(VOTES / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VW-1:0]         round_q, round_d;
    logic [VW-1:0]         round_inc;
    logic [STAGES-1:0]     chal_q, chal_d;
    logic                  launch_q, launch_d;
    logic                  clear_votes;
    logic                  sample_en;
    logic                  done_load;

    logic [CHANNELS-1:0]   arb_win;
    logic [CHANNELS-1:0]   arb_raw;
    logic [CHANNELS-1:0]   sync1_q, sync2_q;
    logic [CHANNELS-1:0]   arb_sync;
    logic [CHANNELS-1:0]   resp_bit_d;
    logic [CHANNELS-1:0]   stable_bit_d;
    logic [CHANNELS-1:0]   resp_q;
    logic [CHANNELS-1:0]   stable_q;

    assign round_inc = round_q + VW'(1);

    // Controller next-state and round bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        round_d     = round_q;
        chal_d      = chal_q;
        clear_votes = 1'b0;
        sample_en   = 1'b0;
        done_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (chal_valid) begin
                    chal_d      = chal;
                    clear_votes = 1'b1;
                    round_d     = '0;
                    cnt_d       = '0;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                if (cnt_q == ARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIRE: begin
                // Two cycles beyond settle so the synchroniser holds the result.
                if (cnt_q == FIRE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                sample_en = 1'b1;
                round_d   = round_inc;
                if (round_inc == VOTES_V) begin
                    done_load = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        launch_d = (state_d == S_FIRE);
    end

    // Controller state registers; reset discards any round in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            round_q  <= '0;
            chal_q   <= '0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            round_q  <= round_d;
            chal_q   <= chal_d;
            launch_q <= launch_d;
        end
    end

    assign chal_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);

    // Per-channel delay chain, arbiter flop and vote counters.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        localparam int ROT = gi % STAGES;

        logic [STAGES-1:0] sel;
        logic              top_end, bot_end;
        logic              win_q;
        logic [VW-1:0]     ones_q, ones_d, ones_inc;

        if (ROT == 0) begin : g_norot
            assign sel = chal_q;
        end else begin : g_rot
            assign sel = {chal_q[STAGES-1-ROT:0], chal_q[STAGES-1:STAGES-ROT]};
        end

        // Switch stages: a set select bit crosses the two race paths. The
        // physical chain needs matched placement; this is its logical model.
        always_comb begin
            logic t_path;
            logic b_path;
            t_path = launch_q;
            b_path = launch_q;
            for (int s = 0; s < STAGES; s++) begin
                if (sel[s]) begin
                    {t_path, b_path} = {b_path, t_path};
                end
            end
            top_end = t_path;
            bot_end = b_path;
        end

        // Arbiter flop: clocked by the bottom path, 1 means the top path won.
        always_ff @(posedge bot_end or negedge rst_n) begin
            if (!rst_n) begin
                win_q <= 1'b0;
            end else begin
                win_q <= top_end;
            end
        end
        assign arb_win[gi] = win_q;

        assign ones_inc = ones_q + VW'(arb_sync[gi]);

        always_comb begin
            ones_d = ones_q;
            if (clear_votes) begin
                ones_d = '0;
            end else if (sample_en) begin
                ones_d = ones_inc;
            end
        end

        // Ones counter for the majority vote.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ones_q <= '0;
            end else begin
                ones_q <= ones_d;
            end
        end

        // Evaluated in SAMPLE of the final round, so include this round's bit.
        assign resp_bit_d[gi] = (ones_inc > HALF_V);

`ifdef APUF_STABILITY_EN
        logic          zero_bit;
        logic [VW-1:0] zeros_q, zeros_d, zeros_inc;

        assign zero_bit  = ~arb_sync[gi];
        assign zeros_inc = zeros_q + VW'(zero_bit);

        always_comb begin
            zeros_d = zeros_q;
            if (clear_votes) begin
                zeros_d = '0;
            end else if (sample_en) begin
                zeros_d = zeros_inc;
            end
        end

        // Zeros counter for the unanimity flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zeros_q <= '0;
            end else begin
                zeros_q <= zeros_d;
            end
        end

        assign stable_bit_d[gi] = (ones_inc == VOTES_V) || (zeros_inc == VOTES_V);
`else
        assign stable_bit_d[gi] = 1'b1;
`endif
    end

    assign arb_raw  = arb_win;
    assign arb_sync = sync2_q;

    // Two-flop synchroniser from the asynchronous race into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= arb_raw;
            sync2_q <= sync1_q;
        end
    end

    // Response registers: loaded on entry to DONE and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q   <= '0;
            stable_q <= '0;
        end else begin
            if (done_load) begin
                resp_q <= resp_bit_d;
            end
`ifdef APUF_STABILITY_EN
            if (done_load) begin
                stable_q <= stable_bit_d;
            end
`else
            stable_q <= stable_bit_d;
`endif
        end
    end

    assign resp        = resp_q;
    assign resp_stable = stable_q;

endmodule

// File: tb/tb_apuf_array_eval.sv
`timescale 1ns/1ps
// Scoreboard bench for apuf_array_eval: default instance plus a minimal
// parameter set. The race result is forced on arb_raw; expectations are
// pushed at acceptance and compared by monitors when resp_valid rises.
module tb_apuf_array_eval;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        chal_valid, chal_ready, resp_valid, resp_ready, busy;
    logic [36:0] chal;
    logic [3:0]  resp, resp_stable;

    logic        s_chal_valid, s_chal_ready, s_resp_valid, s_resp_ready, s_busy;
    logic [7:0]  s_chal;
    logic [0:0]  s_resp, s_resp_stable;

    logic [3:0]  arb_val;
    logic [0:0]  s_arb_val;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] resp;
        logic [3:0] stable;
        int         acc;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t s_exp_q[$];

`ifdef APUF_STABILITY_EN
    localparam logic [3:0] MAJ_STABLE = 4'b1100;
`else
    localparam logic [3:0] MAJ_STABLE = 4'b1111;
`endif

    apuf_array_eval dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chal_valid  (chal_valid),
        .chal_ready  (chal_ready),
        .chal        (chal),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp        (resp),
        .resp_stable (resp_stable),
        .busy        (busy)
    );

    apuf_array_eval #(
        .STAGES(8), .CHANNELS(1), .SETTLE_CYCLES(1), .VOTES(1)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .chal_valid  (s_chal_valid),
        .chal_ready  (s_chal_ready),
        .chal        (s_chal),
        .resp_valid  (s_resp_valid),
        .resp_ready  (s_resp_ready),
        .resp        (s_resp),
        .resp_stable (s_resp_stable),
        .busy        (s_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic set_arb(input logic [3:0] v);
        arb_val = v;
        force dut.arb_raw = arb_val;
    endtask

    // Offer a challenge on the default instance; optionally push its expectation.
    task automatic offer(input logic [36:0] c, input logic [3:0] r, input logic [3:0] st,
                         input bit push, output int acc);
        @(negedge clk);
        chal       = c;
        chal_valid = 1'b1;
        for (int n = 0; n < 400 && !chal_ready; n++) @(negedge clk);
        if (!chal_ready) bound_fail("accept_wait");
        @(posedge clk);
        #1;
        acc        = cyc;
        chal_valid = 1'b0;
        if (push) exp_q.push_back('{r, st, acc, 95});
        $display("offer chal=%h accepted at cycle %0d", c, acc);
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (chal_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) bound_fail(name);
    endtask

    // Monitor for the default instance.
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp=%h with no expectation queued", resp);
            end else begin
                e = exp_q.pop_front();
                $display("resp=%h stable=%h latency=%0d", resp, resp_stable, cyc - e.acc);
                check("resp", {28'd0, resp}, {28'd0, e.resp});
                check("resp_stable", {28'd0, resp_stable}, {28'd0, e.stable});
                check("latency", cyc - e.acc, e.lat);
            end
        end
        prev_rv = resp_valid;
    end

    // Monitor for the minimal-parameter instance.
    logic s_prev_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (s_resp_valid && !s_prev_rv) begin
            if (s_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_resp: got resp=%h with no expectation queued", s_resp);
            end else begin
                e = s_exp_q.pop_front();
                $display("small resp=%h stable=%h latency=%0d", s_resp, s_resp_stable, cyc - e.acc);
                check("s_resp", {31'd0, s_resp}, {28'd0, e.resp});
                check("s_resp_stable", {31'd0, s_resp_stable}, {28'd0, e.stable});
                check("s_latency", cyc - e.acc, e.lat);
            end
        end
        s_prev_rv = s_resp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev_acc;
        logic [3:0] maj_vec [5];

        maj_vec[0] = 4'b0011;
        maj_vec[1] = 4'b0011;
        maj_vec[2] = 4'b0001;
        maj_vec[3] = 4'b0000;
        maj_vec[4] = 4'b0000;

        rst_n        = 1'b1;
        chal_valid   = 1'b0;
        chal         = '0;
        resp_ready   = 1'b1;
        s_chal_valid = 1'b0;
        s_chal       = '0;
        s_resp_ready = 1'b1;
        s_arb_val    = 1'b0;
        force dut_s.arb_raw = s_arb_val;
        set_arb(4'b0000);
        #1;
        rst_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_chal_ready", {31'd0, chal_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp", {28'd0, resp}, 32'd0);
        check("rst_resp_stable", {28'd0, resp_stable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_launch", {31'd0, dut.launch_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency with a constant race result.
        set_arb(4'b1010);
        offer(37'h12_3456_789A, 4'b1010, 4'b1111, 1'b1, acc);
        wait_idle("latency_idle");

        // Majority vote with per-round race results.
        set_arb(maj_vec[0]);
        offer(37'h0F_0F0F_0F0F, 4'b0001, MAJ_STABLE, 1'b1, acc);
        for (int r = 1; r < 5; r++) begin
            while (cyc < acc + r * 19 + 1) @(negedge clk);
            set_arb(maj_vec[r]);
        end
        wait_idle("majority_idle");

        // Back-pressure: response held, no new challenge accepted.
        set_arb(4'b0110);
        resp_ready = 1'b0;
        offer(37'h1A_5A5A_5A5A, 4'b0110, 4'b1111, 1'b1, acc);
        for (int n = 0; n < 200 && !resp_valid; n++) @(negedge clk);
        if (!resp_valid) bound_fail("bp_resp_wait");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_resp", {28'd0, resp}, 32'h6);
            check("bp_chal_ready", {31'd0, chal_ready}, 32'd0);
            check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            if (i == 5) begin
                chal       = 37'h00_DEAD_BEEF;
                chal_valid = 1'b1;
            end
            if (i == 6) chal_valid = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, chal_ready}, 32'd1);
        check("bp_resp_held", {28'd0, resp}, 32'h6);
        $display("back-pressure released at cycle %0d", cyc);

        // Back-to-back acceptances with both handshakes always ready.
        set_arb(4'b1001);
        @(negedge clk);
        chal       = 37'h05_4321_0FED;
        chal_valid = 1'b1;
        prev_acc   = 0;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 400 && !chal_ready; n++) @(negedge clk);
            if (!chal_ready) bound_fail("b2b_accept_wait");
            @(posedge clk);
            #1;
            acc = cyc;
            exp_q.push_back('{4'b1001, 4'b1111, acc, 95});
            $display("b2b accept %0d at cycle %0d", k, acc);
            if (k > 0) check("b2b_gap", acc - prev_acc, 97);
            prev_acc = acc;
            if (k == 2) chal_valid = 1'b0;
            @(negedge clk);
        end
        wait_idle("b2b_idle");

        // Reset during FIRE of round 2, then a clean run.
        set_arb(4'b0101);
        offer(37'h15_5555_5555, 4'b0000, 4'b0000, 1'b0, acc);
        while (cyc < acc + 30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_chal_ready", {31'd0, chal_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_launch", {31'd0, dut.launch_q}, 32'd0);
        check("midrst_resp", {28'd0, resp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        offer(37'h0A_AAAA_AAAA, 4'b0101, 4'b1111, 1'b1, acc);
        wait_idle("midrst_idle");

        // Minimal parameter set.
        for (int v = 0; v < 2; v++) begin
            s_arb_val = (v == 0) ? 1'b1 : 1'b0;
            force dut_s.arb_raw = s_arb_val;
            @(negedge clk);
            s_chal       = 8'hA5;
            s_chal_valid = 1'b1;
            for (int n = 0; n < 50 && !s_chal_ready; n++) @(negedge clk);
            if (!s_chal_ready) bound_fail("s_accept_wait");
            @(posedge clk);
            #1;
            acc          = cyc;
            s_chal_valid = 1'b0;
            s_exp_q.push_back('{{3'b000, s_arb_val}, 4'b0001, acc, 5});
            $display("small offer accepted at cycle %0d arb=%0d", acc, s_arb_val);
            for (int n = 0; n < 50 && s_exp_q.size() != 0; n++) @(negedge clk);
            repeat (3) @(negedge clk);
        end

        // Drain.
        for (int n = 0; n < 400 && (exp_q.size() != 0 || s_exp_q.size() != 0); n++) @(negedge clk);
        if (exp_q.size() != 0 || s_exp_q.size() != 0) bound_fail("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
